// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: PC register, credit-limited in-order fetch issue,
// in-flight/discard tracking for redirects, and a DEPTH-entry prefetch FIFO
// holding {instruction, fetch address} for the IF/ID boundary.
module if_stage_prefetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              freeze,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CW1-1:0]    DEPTH_C = CW1'(DEPTH);

    typedef logic [CW-1:0] cnt_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    cnt_t              infl_q, infl_d;
    cnt_t              drop_q, drop_d;
    cnt_t              cnt_q, cnt_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic           rsp_ok;
    logic           push;
    logic           pop;
    logic [CW1-1:0] credit;

    // Conservative credit: occupied entries plus outstanding requests.
    assign credit   = {1'b0, cnt_q} + {1'b0, infl_q};
    assign mem_req  = !rst && !branch_taken && (credit < DEPTH_C);
    assign mem_addr = pc_q;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok = mem_rvalid && (infl_q != '0);
    assign push   = rsp_ok && !branch_taken && (drop_q == '0);
    assign pop    = out_valid && !freeze && !branch_taken;

    assign out_valid = (cnt_q != '0);
    assign out_inst  = inst_mem[rptr_q];
    assign out_pc    = pc_mem[rptr_q] + STEP;

    // Next-state for PC, response PC, counters and FIFO pointers.
    always_comb begin
        pc_d   = pc_q;
        rpc_d  = rpc_q;
        drop_d = drop_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        infl_d = infl_q + cnt_t'(mem_req) - cnt_t'(rsp_ok);
        if (mem_req) begin
            pc_d = pc_q + STEP;
        end
        if (branch_taken) begin
            pc_d   = branch_addr;
            rpc_d  = branch_addr;
            // Every request still outstanding after this edge is stale. drop
            // is always a subset of inflight, so it is replaced rather than
            // accumulated; back-to-back redirects would otherwise over-count.
            drop_d = infl_q - cnt_t'(rsp_ok);
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (push) begin
                wptr_d = wptr_q + PW'(1);
                rpc_d  = rpc_q + STEP;
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            rpc_q  <= RESET_PC;
            infl_q <= '0;
            drop_q <= '0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            pc_q   <= pc_d;
            rpc_q  <= rpc_d;
            infl_q <= infl_d;
            drop_q <= drop_d;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // FIFO storage write; contents are don't-care while count is zero.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            inst_mem[wptr_q] <= mem_rdata;
            pc_mem[wptr_q]   <= rpc_q;
        end
    end
endmodule

// File: tb/tb_if_stage_prefetch.sv
// Directed bench for if_stage_prefetch with an in-order fixed-latency
// instruction memory model; mem[a] = a ^ 32'hCAFE0000.
module tb_if_stage_prefetch;
    logic        clk;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        freeze;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [31:0] qa[$];
    int          qd[$];

    if_stage_prefetch #(
        .ADDR_W(32), .INST_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .freeze(freeze), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: capture this cycle's request, advance, present due response.
    task automatic tick();
        logic        r;
        logic        rs;
        logic [31:0] a;
        r  = mem_req;
        a  = mem_addr;
        rs = rst;
        @(posedge clk);
        #1;
        if (rs) begin
            qa.delete();
            qd.delete();
        end else if (r) begin
            qa.push_back(a);
            qd.push_back(cyc + lat);
        end
        cyc++;
        if (qd.size() != 0 && qd[0] == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = qa[0] ^ 32'hCAFE0000;
            void'(qa.pop_front());
            void'(qd.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1; branch_taken = 1'b0; branch_addr = '0; freeze = 1'b0;
        lat = l;
        tick();
        tick();
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; branch_taken = 1'b0; branch_addr = '0; freeze = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;

        // Latency 1 stream
        do_reset(1);
        #1; chk("t1_req0", {31'b0, mem_req}, 32'd1); chk("t1_addr0", mem_addr, 32'h0);
        chk("t1_ov0", {31'b0, out_valid}, 32'd0); tick();
        #1; chk("t1_addr1", mem_addr, 32'h4); chk("t1_ov1", {31'b0, out_valid}, 32'd0); tick();
        #1; chk("t1_addr2", mem_addr, 32'h8); chk("t1_ov2", {31'b0, out_valid}, 32'd1);
        chk("t1_pc2", out_pc, 32'h4); chk("t1_inst2", out_inst, 32'hCAFE0000); tick();
        #1; chk("t1_pc3", out_pc, 32'h8); chk("t1_inst3", out_inst, 32'hCAFE0004); tick();
        #1; chk("t1_pc4", out_pc, 32'hC); chk("t1_inst4", out_inst, 32'hCAFE0008); tick();

        // Freeze for 8 cycles fills the FIFO, then drains without gaps
        do_reset(1);
        freeze = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k >= 4) chk("t2_req_full", {31'b0, mem_req}, 32'd0);
            if (k >= 2) chk("t2_pc_hold", out_pc, 32'h4);
            tick();
        end
        freeze = 1'b0;
        #1; chk("t2_req_full_pop", {31'b0, mem_req}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (k != 0) #1;
            chk("t2_ov", {31'b0, out_valid}, 32'd1);
            chk("t2_pc", out_pc, 32'h4 + 32'(4 * k));
            chk("t2_inst", out_inst, (32'(4 * k)) ^ 32'hCAFE0000);
            tick();
        end

        // Latency 3, redirect with three fetches in flight
        do_reset(3);
        for (int k = 0; k < 3; k++) begin #1; tick(); end
        branch_taken = 1'b1; branch_addr = 32'h100;
        #1; chk("t3_req_br", {31'b0, mem_req}, 32'd0); tick();
        branch_taken = 1'b0;
        #1; chk("t3_addr", mem_addr, 32'h100); chk("t3_req", {31'b0, mem_req}, 32'd1);
        chk("t3_ov4", {31'b0, out_valid}, 32'd0); tick();
        for (int k = 0; k < 3; k++) begin
            #1; chk("t3_ov_drop", {31'b0, out_valid}, 32'd0); tick();
        end
        #1; chk("t3_ov8", {31'b0, out_valid}, 32'd1); chk("t3_pc8", out_pc, 32'h104);
        chk("t3_inst8", out_inst, 32'hCAFE0100); tick();
        #1; chk("t3_pc9", out_pc, 32'h108); chk("t3_inst9", out_inst, 32'hCAFE0104); tick();

        // Redirect coinciding with a response and freeze
        do_reset(1);
        freeze = 1'b1;
        #1; tick();
        #1; tick();
        branch_taken = 1'b1; branch_addr = 32'h40;
        #1; chk("t4_ov_pre", {31'b0, out_valid}, 32'd1); chk("t4_req_br", {31'b0, mem_req}, 32'd0);
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        #1; chk("t4_ov_flush", {31'b0, out_valid}, 32'd0); chk("t4_addr", mem_addr, 32'h40);
        chk("t4_req", {31'b0, mem_req}, 32'd1); tick();
        #1; chk("t4_ov_wait", {31'b0, out_valid}, 32'd0); tick();
        #1; chk("t4_ov", {31'b0, out_valid}, 32'd1); chk("t4_pc", out_pc, 32'h44);
        chk("t4_inst", out_inst, 32'hCAFE0040); tick();

        // Back-to-back redirects, latency 2
        do_reset(2);
        #1; tick();
        #1; tick();
        branch_taken = 1'b1; branch_addr = 32'h200;
        #1; tick();
        branch_addr = 32'h300;
        #1; chk("t5_req_br2", {31'b0, mem_req}, 32'd0); tick();
        branch_taken = 1'b0;
        #1; chk("t5_addr", mem_addr, 32'h300); chk("t5_req", {31'b0, mem_req}, 32'd1);
        chk("t5_ov4", {31'b0, out_valid}, 32'd0); tick();
        for (int k = 0; k < 2; k++) begin
            #1; chk("t5_ov_wait", {31'b0, out_valid}, 32'd0); tick();
        end
        #1; chk("t5_ov", {31'b0, out_valid}, 32'd1); chk("t5_pc7", out_pc, 32'h304);
        chk("t5_inst7", out_inst, 32'hCAFE0300); tick();
        #1; chk("t5_pc8", out_pc, 32'h308); chk("t5_inst8", out_inst, 32'hCAFE0304); tick();

        // Reset with full FIFO, then a spurious response
        do_reset(1);
        freeze = 1'b1;
        for (int k = 0; k < 6; k++) begin #1; tick(); end
        #1; chk("t6_full_ov", {31'b0, out_valid}, 32'd1); chk("t6_full_req", {31'b0, mem_req}, 32'd0);
        rst = 1'b1;
        #1; chk("t6_rst_req", {31'b0, mem_req}, 32'd0); tick();
        rst = 1'b0; freeze = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1; chk("t6_ov", {31'b0, out_valid}, 32'd0); chk("t6_req", {31'b0, mem_req}, 32'd1);
        chk("t6_addr", mem_addr, 32'h0); tick();
        #1; chk("t6_spur_ov", {31'b0, out_valid}, 32'd0); tick();
        #1; chk("t6_ov9", {31'b0, out_valid}, 32'd1); chk("t6_pc9", out_pc, 32'h4);
        chk("t6_inst9", out_inst, 32'hCAFE0000); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
